// File: rtl/branch_resolve_unit.sv
// Branch resolution for the E stage. It sorts the E instruction into branch,
// JAL, JALR or none and resolves the actual direction and target. It raises a
// mispredict with the corrected next PC. It also keeps a four-entry 2-bit
// saturating direction predictor and two saturating statistics counters.
//
// Ports:
//   CLK, RST             rising-edge clock, synchronous active-high reset
//   branch_numberE       predictor index of the resolving E instruction
//   pcEj, immEj          E instruction PC and offset (13-bit, wrapping)
//   reg_data1Ej/2Ej      rs1 / rs2 operands
//   jump_codeEj          00 none, 01 JAL, 10 JALR, 11 none
//   branch_codeEj        001 BEQ .. 110 BGEU, 000/111 none
//   predict_takenE       direction predicted at fetch for the E instruction
//   branch_numberF       fetch-side predictor lookup index
//   predict_takenF       prediction for branch_numberF (pre-update value)
//   fail_predict         combinational mispredict, flushes F/D and D/E
//   redirect_pc          combinational corrected next PC
//   branch_cnt, miss_cnt saturating resolved-branch / mispredict counters
module branch_resolve_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  branch_numberE,
  input  logic [12:0] pcEj,
  input  logic [31:0] reg_data1Ej,
  input  logic [31:0] reg_data2Ej,
  input  logic [12:0] immEj,
  input  logic [1:0]  jump_codeEj,
  input  logic [2:0]  branch_codeEj,
  input  logic        predict_takenE,
  input  logic [1:0]  branch_numberF,
  output logic        predict_takenF,
  output logic        fail_predict,
  output logic [12:0] redirect_pc,
  output logic [15:0] branch_cnt,
  output logic [15:0] miss_cnt
);

  localparam int unsigned PC_W    = 13;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned ENTRIES = 4;

  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;

  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_MAX   = 2'b11;
  localparam logic [1:0] CTR_MIN   = 2'b00;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_BRANCH = 2'd1,
    CLS_JAL    = 2'd2,
    CLS_JALR   = 2'd3
  } inst_class_e;

  inst_class_e           cls;
  logic                  op_eq;
  logic                  op_lt_s;
  logic                  op_lt_u;
  logic                  cond_taken;
  logic                  actual_taken;
  logic [PC_W-1:0]       pc_target;
  logic [PC_W-1:0]       jalr_sum;
  logic [PC_W-1:0]       jalr_target;
  logic [PC_W-1:0]       fall_through;
  logic                  fail_c;
  logic [PC_W-1:0]       redirect_c;

  logic [ENTRIES-1:0][1:0] ctr_q;
  logic [1:0]              ctr_cur;
  logic [1:0]              ctr_nxt;
  logic [CNT_W-1:0]        branch_cnt_q;
  logic [CNT_W-1:0]        miss_cnt_q;

  // Instruction class; a jump code overrides any branch code.
  always_comb begin
    cls = CLS_NONE;
    if (jump_codeEj == JMP_JAL) begin
      cls = CLS_JAL;
    end else if (jump_codeEj == JMP_JALR) begin
      cls = CLS_JALR;
    end else if (branch_codeEj != 3'd0 && branch_codeEj != 3'd7) begin
      cls = CLS_BRANCH;
    end
  end

  // Operand comparisons.
  assign op_eq   = (reg_data1Ej == reg_data2Ej);
  assign op_lt_s = ($signed(reg_data1Ej) < $signed(reg_data2Ej));
  assign op_lt_u = (reg_data1Ej < reg_data2Ej);

  // Conditional branch direction from the comparison results.
  always_comb begin
    cond_taken = 1'b0;
    case (branch_codeEj)
      BR_BEQ:  cond_taken = op_eq;
      BR_BNE:  cond_taken = !op_eq;
      BR_BLT:  cond_taken = op_lt_s;
      BR_BGE:  cond_taken = !op_lt_s;
      BR_BLTU: cond_taken = op_lt_u;
      BR_BGEU: cond_taken = !op_lt_u;
      default: cond_taken = 1'b0;
    endcase
  end

  // Jumps are always taken; class none never is.
  always_comb begin
    actual_taken = 1'b0;
    case (cls)
      CLS_BRANCH: actual_taken = cond_taken;
      CLS_JAL:    actual_taken = 1'b1;
      CLS_JALR:   actual_taken = 1'b1;
      default:    actual_taken = 1'b0;
    endcase
  end

  // Target and fall-through addresses, all wrapping at the PC width.
  assign pc_target    = pcEj + immEj;
  assign jalr_sum     = reg_data1Ej[PC_W-1:0] + immEj;
  assign jalr_target  = {jalr_sum[PC_W-1:1], 1'b0};
  assign fall_through = pcEj + PC_W'(4);

  // Mispredict decision and the corrected next PC.
  always_comb begin
    fail_c     = 1'b0;
    redirect_c = '0;
    case (cls)
      CLS_BRANCH: begin
        fail_c     = (actual_taken != predict_takenE);
        redirect_c = actual_taken ? pc_target : fall_through;
      end
      CLS_JAL: begin
        fail_c     = (actual_taken != predict_takenE);
        redirect_c = pc_target;
      end
      CLS_JALR: begin
        // The predictor never knows the register target, so always redirect.
        fail_c     = 1'b1;
        redirect_c = jalr_target;
      end
      default: begin
        fail_c     = 1'b0;
        redirect_c = '0;
      end
    endcase
  end

  assign fail_predict = fail_c;
  assign redirect_pc  = redirect_c;

  // Saturating next value for the entry the E branch resolves.
  always_comb begin
    ctr_cur = ctr_q[branch_numberE];
    ctr_nxt = ctr_cur;
    if (actual_taken) begin
      if (ctr_cur != CTR_MAX) begin
        ctr_nxt = ctr_cur + 2'd1;
      end
    end else begin
      if (ctr_cur != CTR_MIN) begin
        ctr_nxt = ctr_cur - 2'd1;
      end
    end
  end

  // The lookup reads the registered table, so a same-cycle update is not seen.
  assign predict_takenF = ctr_q[branch_numberF][1];

  // Predictor table and statistics; reset wins over any update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ctr_q        <= {ENTRIES{CTR_RESET}};
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (cls == CLS_BRANCH) begin
        ctr_q[branch_numberE] <= ctr_nxt;
      end
      if (cls != CLS_NONE && branch_cnt_q != '1) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
      if (fail_c && miss_cnt_q != '1) begin
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-002 CLK  in  1  rising-edge clock.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 branch_numberE  in  2  predictor-table index of the branch in E.
REQ-005 pcEj  in  13  PC of the E instruction.
REQ-006 reg_data1Ej, reg_data2Ej  in  32 each  rs1 and rs2 operands.
REQ-007 immEj  in  13  offset, added modulo 2^13.
REQ-008 jump_codeEj  in  2  00 none, 01 JAL, 10 JALR, 11 none.
REQ-009 branch_codeEj  in  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 none.
REQ-010 predict_takenE  in  1  direction predicted at fetch for the E instruction.
REQ-011 branch_numberF  in  2  predictor lookup index from fetch.
REQ-012 predict_takenF  out  1  prediction for branch_numberF.
REQ-013 fail_predict  out  1  mispredict; flushes the D/E and F/D registers.
REQ-014 redirect_pc  out  13  correct next PC; valid while fail_predict=1.
REQ-015 branch_cnt, miss_cnt  out  16 each  saturating statistics counters.

Function
REQ-016 Instruction class: conditional branch if branch_codeEj is 001..110; JAL if jump_codeEj=01; JALR if jump_codeEj=10; otherwise none. If both codes are active, the jump SHALL take priority.
REQ-017 Actual taken: JAL and JALR are always taken. BEQ is eq and BNE is !eq. BLT/BGE use a 32-bit signed compare; BLTU/BGEU use an unsigned compare. Class none is never taken.
REQ-018 Target: branch and JAL use pcEj+immEj; JALR uses (reg_data1Ej[12:0]+immEj) with bit0 forced to 0. Fall-through is pcEj+4. All sums SHALL wrap modulo 2^13.
REQ-019 fail_predict is combinational from the E inputs:
  - branch or JAL: actual taken != predict_takenE.
  - JALR: always 1.
  - none: always 0.
REQ-020 redirect_pc SHALL be the target if actually taken, otherwise pcEj+4. It SHALL be 0 when class is none.
REQ-021 The predictor SHALL be a table of four 2-bit saturating counters. predict_takenF = counter[branch_numberF][1].
REQ-022 Update at the rising edge, for conditional branches only: taken increments the counter, saturating at 11; not-taken decrements it, saturating at 00. JAL, JALR and none SHALL leave the table unchanged.
REQ-023 Lookup and update to the same index in the same cycle SHALL return the pre-update value (read-before-write).
REQ-024 branch_cnt SHALL increment once per cycle whose class is branch, JAL or JALR.
REQ-025 miss_cnt SHALL increment once per cycle with fail_predict=1.
REQ-026 Both counters SHALL saturate at 0xFFFF.
REQ-027 Bubbles, meaning both codes zeroed by an upstream stall or flush, SHALL be class none. They SHALL produce no update, no count and no fail_predict.
REQ-028 The block SHALL have one-cycle state latency: a table or counter change is visible on outputs the cycle after the resolving edge.

Reset
REQ-029 While RST=1 at a rising edge:
  - every counter in the table SHALL be set to 01;
  - branch_cnt and miss_cnt SHALL be set to 0.
REQ-030 Reset SHALL take priority over any simultaneous update.
REQ-031 After reset, predict_takenF=0 for all indices.
REQ-032 The combinational fail_predict and redirect_pc SHALL still follow the E inputs while RST=1.

Verification
REQ-033 BEQ, rs1=rs2=5, pc=0x0100, imm=0x0010, predict_takenE=0:
  - fail_predict=1, redirect_pc=0x0110;
  - next cycle: counter[idx]=10, branch_cnt=1, miss_cnt=1.
REQ-034 rs1=0xFFFFFFFF, rs2=1:
  - BLT: taken;
  - BLTU: not taken, and with predict_takenE=1, fail_predict=1 and redirect_pc=pc+4;
  - pc=0x1FFC: redirect_pc wraps to 0x0000.
REQ-035 JALR, rs1=0x00000123, imm=0x0004: fail_predict=1, redirect_pc=0x0126, table unchanged, branch_cnt+1.
REQ-036 Four taken BNE on index 2, then lookup at index 2:
  - counter=11, predict_takenF=1;
  - a same-cycle lookup during the update that moves the counter 01->10 returns 0.
REQ-037 Reset mid-stream: miss_cnt=3 and counter[1]=11, then RST=1 for one edge alongside a taken branch on index 1 -> counters 0, all table entries 01.
REQ-038 Bubble (both codes 0) with arbitrary operands:
  - fail_predict=0, redirect_pc=0;
  - no table or counter change.
